// File: rtl/bus_ppu_chr_if.sv
// Run-time SDRAM read port shared with bus6502: single-byte request/response handshake.
interface bus_ppu_chr_if;
  logic [22:0] ram_addr;
  logic        in_valid;
  logic        busy;
  logic [7:0]  data_out;
  logic        out_valid;

  modport master (
    output ram_addr,
    output in_valid,
    input  busy,
    input  data_out,
    input  out_valid
  );

  modport slave (
    input  ram_addr,
    input  in_valid,
    output busy,
    output data_out,
    output out_valid
  );
endinterface

// File: rtl/bus_ppu_chr.sv
// Serves PPU pattern-table (CHR) reads from SDRAM with strobe synchronisation,
// a one-entry last-address cache, a one-deep pending slot and a fetch timeout.
module bus_ppu_chr #(
  parameter logic [22:0] CHR_BASE    = 23'h008000,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [13:0]   ppu_addr,
  input  logic          ppu_rd_n,
  output logic [7:0]    ppu_data_out,
  output logic          error,
  bus_ppu_chr_if.master sdram
);

  localparam int unsigned AW = 14;
  localparam int unsigned CW = 13;
  localparam int unsigned DW = 8;
  localparam int unsigned RW = 23;
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DATA} state_t;

  logic [AW-1:0]          addr_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] rd_sync;
  logic                   rd_prev;
  logic                   en_prev;

  logic [AW-1:0] addr_s;
  logic          rd_s;
  logic          strobe_c;
  logic [CW-1:0] new_addr_c;
  logic          hit_c;

  state_t        state, state_d;
  logic [CW-1:0] req_addr, req_addr_d;
  logic [CW-1:0] pend_addr, pend_addr_d;
  logic          pending, pending_d;
  logic [CW-1:0] cache_addr, cache_addr_d;
  logic          cache_valid, cache_valid_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic [DW-1:0] data_d;
  logic [RW-1:0] ram_addr_q, ram_addr_d;
  logic          in_valid_q, in_valid_d;
  logic          error_d;

  logic          done_c;
  logic          fill_hit_c;
  logic          have_next_c;
  logic [CW-1:0] next_addr_c;

  function automatic logic [RW-1:0] chr_addr(input logic [CW-1:0] a);
    return CHR_BASE + RW'(a);
  endfunction

  // Synchronisers; rd_n resets low so a strobe held across reset needs a fresh falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) addr_sync[i] <= '0;
      rd_sync <= '0;
      rd_prev <= 1'b0;
      en_prev <= 1'b0;
    end else begin
      addr_sync[0] <= ppu_addr;
      rd_sync[0]   <= ppu_rd_n;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        addr_sync[i] <= addr_sync[i-1];
        rd_sync[i]   <= rd_sync[i-1];
      end
      rd_prev <= rd_sync[SYNC_STAGES-1];
      en_prev <= enable;
    end
  end

  assign addr_s     = addr_sync[SYNC_STAGES-1];
  assign rd_s       = rd_sync[SYNC_STAGES-1];
  assign strobe_c   = rd_prev && !rd_s && !addr_s[13];
  assign new_addr_c = addr_s[CW-1:0];
  // A cache entry is not trusted in the cycle enable rises; it is being invalidated.
  assign hit_c      = cache_valid && en_prev && (new_addr_c == cache_addr);

  assign sdram.ram_addr = ram_addr_q;
  assign sdram.in_valid = in_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_addr     <= '0;
      pend_addr    <= '0;
      pending      <= 1'b0;
      cache_addr   <= '0;
      cache_valid  <= 1'b0;
      tcnt         <= '0;
      ppu_data_out <= '0;
      ram_addr_q   <= '0;
      in_valid_q   <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_d;
      req_addr     <= req_addr_d;
      pend_addr    <= pend_addr_d;
      pending      <= pending_d;
      cache_addr   <= cache_addr_d;
      cache_valid  <= cache_valid_d;
      tcnt         <= tcnt_d;
      ppu_data_out <= data_d;
      ram_addr_q   <= ram_addr_d;
      in_valid_q   <= in_valid_d;
      error        <= error_d;
    end
  end

  always_comb begin
    state_d       = state;
    req_addr_d    = req_addr;
    pend_addr_d   = pend_addr;
    pending_d     = pending;
    cache_addr_d  = cache_addr;
    cache_valid_d = cache_valid;
    tcnt_d        = tcnt;
    data_d        = ppu_data_out;
    ram_addr_d    = ram_addr_q;
    in_valid_d    = 1'b0;
    error_d       = error;
    done_c        = 1'b0;
    fill_hit_c    = 1'b0;
    // A strobe landing in the completion cycle is newer than the pending slot.
    next_addr_c   = strobe_c ? new_addr_c : pend_addr;
    have_next_c   = enable && (strobe_c || pending);

    case (state)
      IDLE: begin
        pending_d = 1'b0;
        if (strobe_c && enable && !hit_c) begin
          req_addr_d = new_addr_c;
          ram_addr_d = chr_addr(new_addr_c);
          if (!sdram.busy) begin
            in_valid_d = 1'b1;
            tcnt_d     = '0;
            state_d    = WAIT_DATA;
          end else begin
            state_d = WAIT_BUSY;
          end
        end
      end

      WAIT_BUSY: begin
        if (!enable) begin
          pending_d = 1'b0;
          state_d   = IDLE;
        end else begin
          if (strobe_c) begin
            pend_addr_d = new_addr_c;
            pending_d   = 1'b1;
          end
          if (!sdram.busy) begin
            in_valid_d = 1'b1;
            tcnt_d     = '0;
            state_d    = WAIT_DATA;
          end
        end
      end

      WAIT_DATA: begin
        tcnt_d = tcnt + TW'(1);
        if (sdram.out_valid) begin
          data_d        = sdram.data_out;
          cache_addr_d  = req_addr;
          cache_valid_d = 1'b1;
          done_c        = 1'b1;
          fill_hit_c    = en_prev && (next_addr_c == req_addr);
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          error_d       = 1'b1;
          cache_valid_d = 1'b0;
          done_c        = 1'b1;
        end

        if (done_c) begin
          pending_d = 1'b0;
          if (have_next_c && !fill_hit_c) begin
            req_addr_d = next_addr_c;
            ram_addr_d = chr_addr(next_addr_c);
            state_d    = WAIT_BUSY;
          end else begin
            state_d = IDLE;
          end
        end else if (strobe_c && enable) begin
          pend_addr_d = new_addr_c;
          pending_d   = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (enable && !en_prev) cache_valid_d = 1'b0;
  end

endmodule

// File: tb/tb_bus_ppu_chr.sv
// Directed bench for bus_ppu_chr: SDRAM responses driven by hand, in_valid pulses logged by a monitor.
module tb_bus_ppu_chr;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [13:0] ppu_addr;
  logic        ppu_rd_n;
  logic [7:0]  ppu_data_out;
  logic        error;

  bus_ppu_chr_if sdram_if ();

  bus_ppu_chr dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .ppu_addr     (ppu_addr),
    .ppu_rd_n     (ppu_rd_n),
    .ppu_data_out (ppu_data_out),
    .error        (error),
    .sdram        (sdram_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int iv_count = 0;
  int iv_cyc = 0;
  logic [22:0] iv_addr = '0;
  int n0;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Logs each in_valid pulse with its address and cycle index.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sdram_if.in_valid) begin
      iv_count <= iv_count + 1;
      iv_addr  <= sdram_if.ram_addr;
      iv_cyc   <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [13:0] a);
    @(negedge clk);
    ppu_addr = a;
    ppu_rd_n = 1'b0;
    tick(3);
    ppu_rd_n = 1'b1;
    tick(3);
  endtask

  task automatic respond(input logic [7:0] d);
    tick(2);
    sdram_if.data_out  = d;
    sdram_if.out_valid = 1'b1;
    tick(1);
    sdram_if.out_valid = 1'b0;
    sdram_if.data_out  = 8'h00;
    tick(2);
  endtask

  initial begin
    rst_n              = 1'b0;
    enable             = 1'b0;
    ppu_addr           = '0;
    ppu_rd_n           = 1'b1;
    sdram_if.busy      = 1'b0;
    sdram_if.data_out  = 8'h00;
    sdram_if.out_valid = 1'b0;
    tick(3);
    check("rst_data", 32'(ppu_data_out), 32'h00);
    check("rst_addr", 32'(sdram_if.ram_addr), 32'h0);
    check("rst_inv", 32'(sdram_if.in_valid), 32'h0);
    check("rst_err", 32'(error), 32'h0);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick(5);

    // Basic miss and fill
    n0 = iv_count;
    strobe(14'h0123);
    check("miss_iv", 32'(iv_count - n0), 32'd1);
    check("miss_addr", 32'(iv_addr), 32'h008123);
    respond(8'hA5);
    check("miss_data", 32'(ppu_data_out), 32'hA5);
    check("miss_err", 32'(error), 32'h0);

    // Cache hit, then neighbouring miss
    n0 = iv_count;
    strobe(14'h0123);
    tick(4);
    check("hit_iv", 32'(iv_count - n0), 32'd0);
    check("hit_data", 32'(ppu_data_out), 32'hA5);
    strobe(14'h0124);
    check("miss2_iv", 32'(iv_count - n0), 32'd1);
    check("miss2_addr", 32'(iv_addr), 32'h008124);
    respond(8'h5A);
    check("miss2_data", 32'(ppu_data_out), 32'h5A);

    // Nametable window ignored
    n0 = iv_count;
    strobe(14'h2400);
    tick(4);
    check("nt_iv", 32'(iv_count - n0), 32'd0);
    check("nt_data", 32'(ppu_data_out), 32'h5A);

    // Busy hold, then latest-wins pending
    sdram_if.busy = 1'b1;
    n0 = iv_count;
    strobe(14'h0010);
    tick(4);
    check("busy_hold_iv", 32'(iv_count - n0), 32'd0);
    sdram_if.busy = 1'b0;
    n0 = n0 + 0;
    begin
      int fall_cyc;
      fall_cyc = cyc;
      tick(3);
      check("busy_iv", 32'(iv_count - n0), 32'd1);
      check("busy_lat", 32'(iv_cyc - fall_cyc), 32'd1);
    end
    check("busy_addr", 32'(iv_addr), 32'h008010);
    strobe(14'h0020);
    strobe(14'h0030);
    check("pend_wait_iv", 32'(iv_count - n0), 32'd1);
    respond(8'h11);
    check("pend_fill1", 32'(ppu_data_out), 32'h11);
    check("pend_iv", 32'(iv_count - n0), 32'd2);
    check("pend_addr", 32'(iv_addr), 32'h008030);
    respond(8'h33);
    check("pend_fill2", 32'(ppu_data_out), 32'h33);
    tick(5);
    check("pend_no_extra", 32'(iv_count - n0), 32'd2);

    // Timeout
    n0 = iv_count;
    strobe(14'h0040);
    check("to_iv", 32'(iv_count - n0), 32'd1);
    check("to_err_pre", 32'(error), 32'h0);
    for (int k = 0; k < 100 && !error; k++) tick(1);
    check("to_err", 32'(error), 32'h1);
    check("to_cycles", 32'(cyc - iv_cyc), 32'd64);
    check("to_data", 32'(ppu_data_out), 32'h33);
    tick(2);
    strobe(14'h0030);
    check("to_refetch_iv", 32'(iv_count - n0), 32'd2);
    check("to_refetch_addr", 32'(iv_addr), 32'h008030);
    respond(8'h77);
    check("to_refetch_data", 32'(ppu_data_out), 32'h77);
    check("to_err_sticky", 32'(error), 32'h1);

    // enable low blocks requests; rising enable drops the cache
    enable = 1'b0;
    tick(2);
    n0 = iv_count;
    strobe(14'h0100);
    strobe(14'h0030);
    tick(4);
    check("dis_iv", 32'(iv_count - n0), 32'd0);
    enable = 1'b1;
    tick(2);
    strobe(14'h0030);
    check("en_rise_iv", 32'(iv_count - n0), 32'd1);
    check("en_rise_addr", 32'(iv_addr), 32'h008030);

    // Asynchronous reset mid-fetch
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_data", 32'(ppu_data_out), 32'h00);
    check("arst_addr", 32'(sdram_if.ram_addr), 32'h0);
    check("arst_inv", 32'(sdram_if.in_valid), 32'h0);
    check("arst_err", 32'(error), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n0 = iv_count;
    tick(10);
    check("post_rst_iv", 32'(iv_count - n0), 32'd0);
    strobe(14'h0123);
    check("post_rst_fetch", 32'(iv_addr), 32'h008123);
    respond(8'hC3);
    check("post_rst_data", 32'(ppu_data_out), 32'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
